button_event_gen: RTL and testbench

Consumer end of the debounced-button path. Takes the clean level from the button debouncer and turns it into single-cycle events: press, release, short click, long press and auto-repeat while held, plus a long-hold status flag. Sits between the debouncer and the design's control FSMs (menu/step logic), so those FSMs never edge-detect or time buttons themselves. One instance per button.

---
 rtl/button_event_gen_pkg.sv | 18 +
 rtl/button_event_gen.sv | 106 ++++++++++
 tb/tb_button_event_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the debounced-button event path: FSM state
// encodings and the default 50 MHz timing constants.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } btn_state_e;

    // Default timing for a 50 MHz clk; the debouncer uses the same base
    localparam int unsigned CLK_HZ                    = 50_000_000;
    localparam int unsigned DEF_CNT_LEN               = 26;
    localparam int unsigned DEF_LONG_PRESS_CYCLES     = 50_000_000; // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES         = 10_000_000; // 200 ms
    localparam int unsigned DEF_DEBOUNCE_VALUE        = 1_000_000;  // 20 ms

endpackage

// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press / release /
// click / long / repeat events plus a long-hold status level.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int unsigned CNT_LEN           = DEF_CNT_LEN,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN         = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held_long
);

    localparam logic [CNT_LEN-1:0] LONG_LAST   = CNT_LEN'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_LEN-1:0] REPEAT_LAST = CNT_LEN'(REPEAT_CYCLES - 1);

    btn_state_e         state_q, state_d;
    logic [CNT_LEN-1:0] cnt_q, cnt_d;
    logic               press_d, release_d, click_d, long_d, repeat_d, held_d;

    // Next-state, next-counter and next-output decode; release is tested
    // first in each held state so it wins over any coincident threshold
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_level) begin
                    press_d = 1'b1;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_LEN'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_level) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else if (!REPEAT_EN) begin
                    cnt_d = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_LEN'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == LONG_HELD);
    end

    // State, counter and registered event outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held_long     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            click_pulse   <= click_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            held_long     <= held_d;
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_PRESS_CYCLES=8,
// REPEAT_CYCLES=4, CNT_LEN=4; a second instance has auto-repeat disabled.
module tb_button_event_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_level = 1'b0;

    logic press_a, release_a, click_a, long_a, repeat_a, held_a;
    logic press_b, release_b, click_b, long_b, repeat_b, held_b;
    logic [5:0] out_a, out_b;

    int errors = 0;
    int checks = 0;

    // Output vector order: {press, release, click, long, repeat, held}
    assign out_a = {press_a, release_a, click_a, long_a, repeat_a, held_a};
    assign out_b = {press_b, release_b, click_b, long_b, repeat_b, held_b};

    always #5 clk = ~clk;

    button_event_gen #(
        .CNT_LEN(4), .LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .btn_level(btn_level),
        .press_pulse(press_a), .release_pulse(release_a), .click_pulse(click_a),
        .long_pulse(long_a), .repeat_pulse(repeat_a), .held_long(held_a)
    );

    button_event_gen #(
        .CNT_LEN(4), .LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .btn_level(btn_level),
        .press_pulse(press_b), .release_pulse(release_b), .click_pulse(click_b),
        .long_pulse(long_b), .repeat_pulse(repeat_b), .held_long(held_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive btn_level, then sample 1 time unit after the next rising edge
    task automatic step(input logic b);
        btn_level = b;
        @(posedge clk);
        #1;
    endtask

    // Expected outputs of a long hold, i = steps since the press edge
    function automatic logic [5:0] exp_hold(input int i);
        if (i == 0)                   return 6'b100000;
        if (i < 8)                    return 6'b000000;
        if (i == 8)                   return 6'b000101;
        if (((i - 8) % 4) == 0)       return 6'b000011;
        return 6'b000001;
    endfunction

    initial begin
        int n_long;
        int n_rep;

        // 1. reset with toggling input, then release with button held
        #1;
        check("rst_t0", out_a, 6'b0);
        step(1'b1); check("rst_hold1", out_a, 6'b0);
        step(1'b0); check("rst_hold2", out_a, 6'b0);
        step(1'b1); check("rst_hold3", out_a, 6'b0);
        reset_n = 1'b1;
        step(1'b1); check("rst_press", out_a, 6'b100000);
        step(1'b1); check("rst_press_once", out_a, 6'b0);
        step(1'b0); check("rst_glitch_rel", out_a, 6'b011000);
        step(1'b0); check("rst_idle", out_a, 6'b0);

        // 2. short click: five high samples then release
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check($sformatf("click_h%0d", i), out_a, (i == 0) ? 6'b100000 : 6'b000000);
        end
        step(1'b0); check("click_rel", out_a, 6'b011000);
        step(1'b0); check("click_after", out_a, 6'b0);

        // 3. long press with repeat; release lands on a repeat threshold
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            check($sformatf("long_h%0d", i), out_a, 32'(exp_hold(i)));
        end
        step(1'b0); check("long_rel_at_rep", out_a, 6'b010000);
        step(1'b0); check("long_after", out_a, 6'b0);

        // 4. release exactly at the long-press threshold
        for (int i = 0; i < 8; i++) step(1'b1);
        check("thr_before", out_a, 6'b0);
        step(1'b0); check("thr_rel_at_long", out_a, 6'b011000);
        step(1'b0); check("thr_after", out_a, 6'b0);

        // 5. auto-repeat disabled instance held for 30 cycles
        n_long = 0;
        n_rep = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1);
            if (long_b) n_long++;
            if (repeat_b) n_rep++;
            if (i == 8) check("norep_long_at8", out_b, 6'b000101);
        end
        check("norep_long_cnt", n_long, 1);
        check("norep_rep_cnt", n_rep, 0);
        check("norep_held", out_b, 6'b000001);
        step(1'b0); check("norep_rel", out_b, 6'b010000);
        step(1'b0); check("norep_after", out_b, 6'b0);

        // 6. asynchronous reset during long hold, restart with button held
        for (int i = 0; i < 10; i++) step(1'b1);
        check("mid_in_long", out_a, 6'b000001);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_async_a", out_a, 6'b0);
        check("mid_async_b", out_b, 6'b0);
        step(1'b1); check("mid_in_reset", out_a, 6'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1);
            if (i == 0) check("mid_press", out_a, 6'b100000);
            if (i == 7) check("mid_pre_long", out_a, 6'b0);
            if (i == 8) check("mid_long", out_a, 6'b000101);
        end
        step(1'b0); check("mid_rel", out_a, 6'b010000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
